argo_chan_arbiter: RTL

Round-robin channel arbiter that shares one Argo channel input, such as an `argo_3stage` pipeline or a channel FIFO, among `NUM_REQ` producer go-routines. Each producer presents an ivalid/iready-style handshake. The arbiter picks one producer per transfer and holds the granted word in a one-entry output register. It then drives that word to the shared consumer using the same ovalid/oready protocol as the pipeline stages. A burst limit keeps one producer from starving the others on a shared channel.

---
 rtl/argo_chan_arbiter_if.sv | 41 ++++
 rtl/argo_chan_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/argo_chan_arbiter_if.sv
// ---------------------------------------------------------------------------
// argo_chan_arbiter_if
// Groups the signals between the channel arbiter and the rest of the system.
// The producer-side signals are NUM_REQ wide. The consumer side is a single
// ovalid/oready channel.
//
//   req_valid  producer -> arbiter  bit i: requester i presents a word
//   req_ready  arbiter -> producer  bit i: word from requester i accepted
//   req_data   producer -> arbiter  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ovalid     arbiter -> consumer  output register holds a word
//   oready     consumer -> arbiter  consumer takes dataout this cycle
//   dataout    arbiter -> consumer  registered granted word
//   grant_id   arbiter -> consumer  requester index that supplied dataout
//
// Modports:
//   master  the arbiter itself
//   slave   the surrounding producers and consumer
// ---------------------------------------------------------------------------
interface argo_chan_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int GRANT_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          ovalid;
    logic                          oready;
    logic [DATA_WIDTH-1:0]         dataout;
    logic [GRANT_W-1:0]            grant_id;

    modport master (
        input  req_valid, req_data, oready,
        output req_ready, ovalid, dataout, grant_id
    );

    modport slave (
        output req_valid, req_data, oready,
        input  req_ready, ovalid, dataout, grant_id
    );
endinterface

// File: rtl/argo_chan_arbiter.sv
// ---------------------------------------------------------------------------
// argo_chan_arbiter
// Round-robin arbiter that shares one Argo channel input among NUM_REQ
// producers. The granted word is held in a one-entry output register and is
// drained with the ovalid/oready protocol. The current owner may keep the
// channel for up to MAX_BURST consecutive transfers.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-low reset
//   bus  argo_chan_arbiter_if.master:
//        req_valid/req_ready/req_data   producer handshakes
//        ovalid/oready/dataout          consumer handshake
//        grant_id                       requester index of dataout
// ---------------------------------------------------------------------------
module argo_chan_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    argo_chan_arbiter_if.master   bus
);
    localparam int GRANT_W = $clog2(NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);

    logic                  ovalid_q,  ovalid_d;
    logic [DATA_WIDTH-1:0] dataout_q, dataout_d;
    logic [GRANT_W-1:0]    grant_q,   grant_d;
    logic [GRANT_W-1:0]    owner_q,   owner_d;
    logic [BURST_W-1:0]    burst_q,   burst_d;

    logic                  slot_free_s;
    logic                  sel_found_s;
    logic [GRANT_W-1:0]    sel_s;
    logic [GRANT_W-1:0]    cand_s;
    logic                  xfer_s;
    logic [NUM_REQ-1:0]    ready_s;
    logic [DATA_WIDTH-1:0] word_s;

    // The output register can load while it is being drained.
    assign slot_free_s = !ovalid_q || bus.oready;

    // Requester selection. The owner stays while it is valid and has burst
    // budget left. burst_q == 0 exists only after reset and means "no owner
    // yet", so the first search starts at owner_q+1 == 0. Otherwise the
    // search runs from owner_q+1, wraps, and visits the owner last, so an
    // exhausted owner still keeps an otherwise idle channel.
    always_comb begin
        sel_s       = owner_q;
        sel_found_s = 1'b0;
        cand_s      = owner_q;
        if (bus.req_valid[owner_q] && (burst_q != '0) && (burst_q < MAX_BURST_C)) begin
            sel_s       = owner_q;
            sel_found_s = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand_s = GRANT_W'((int'(owner_q) + k) % NUM_REQ);
                if (!sel_found_s && bus.req_valid[cand_s]) begin
                    sel_s       = cand_s;
                    sel_found_s = 1'b1;
                end else begin
                    sel_found_s = sel_found_s;
                end
            end
        end
    end

    // One-hot accept and data mux for the selected requester.
    always_comb begin
        ready_s = '0;
        word_s  = '0;
        xfer_s  = sel_found_s && slot_free_s && rst;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_s == GRANT_W'(i)) begin
                ready_s[i] = xfer_s;
                word_s     = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                ready_s[i] = 1'b0;
            end
        end
    end

    assign bus.req_ready = ready_s;

    // Next-state: load on a transfer, drain when accepted, otherwise hold.
    always_comb begin
        ovalid_d  = ovalid_q;
        dataout_d = dataout_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        burst_d   = burst_q;
        if (xfer_s) begin
            ovalid_d  = 1'b1;
            dataout_d = word_s;
            grant_d   = sel_s;
            if ((sel_s == owner_q) && (burst_q < MAX_BURST_C)) begin
                burst_d = burst_q + BURST_W'(1);
            end else begin
                owner_d = sel_s;
                burst_d = BURST_W'(1);
            end
        end else if (bus.oready) begin
            ovalid_d = 1'b0;
        end else begin
            ovalid_d = ovalid_q;
        end
    end

    // State register; reset drops any held word and restarts the search at 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovalid_q  <= 1'b0;
            dataout_q <= '0;
            grant_q   <= '0;
            owner_q   <= GRANT_W'(NUM_REQ - 1);
            burst_q   <= '0;
        end else begin
            ovalid_q  <= ovalid_d;
            dataout_q <= dataout_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            burst_q   <= burst_d;
        end
    end

    assign bus.ovalid   = ovalid_q;
    assign bus.dataout  = dataout_q;
    assign bus.grant_id = grant_q;

endmodule
